// File: rtl/div_iter_axis.sv
// Iterative 32-bit divider with two AXI-Stream operand channels.
// Restoring radix-2, one quotient bit per cycle, MSB first.
module div_iter_axis #(
    parameter bit SIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_axis_divisor_tvalid,
    output logic        s_axis_divisor_tready,
    input  logic [31:0] s_axis_divisor_tdata,
    input  logic        s_axis_dividend_tvalid,
    output logic        s_axis_dividend_tready,
    input  logic [31:0] s_axis_dividend_tdata,
    output logic        m_axis_dout_tvalid,
    output logic [63:0] m_axis_dout_tdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic        dvs_held;
    logic        dvd_held;
    logic [31:0] dvs_hold;
    logic [31:0] dvd_hold;
    logic [31:0] dvs_mag;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        q_neg;
    logic        r_neg;
    logic [5:0]  count;

    logic        dvs_xfer;
    logic        dvd_xfer;
    logic        start;
    logic [31:0] dvs_op;
    logic [31:0] dvd_op;
    logic        dvs_neg;
    logic        dvd_neg;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        fits;
    logic [31:0] nxt_rem;
    logic [31:0] nxt_quo;

    assign dvs_xfer = s_axis_divisor_tvalid & s_axis_divisor_tready;
    assign dvd_xfer = s_axis_dividend_tvalid & s_axis_dividend_tready;

    // An operand arriving this edge bypasses its holding register.
    assign dvs_op = dvs_held ? dvs_hold : s_axis_divisor_tdata;
    assign dvd_op = dvd_held ? dvd_hold : s_axis_dividend_tdata;

    assign start = (state == IDLE)
                 & (dvs_held | dvs_xfer)
                 & (dvd_held | dvd_xfer);

    assign dvs_neg = SIGNED & dvs_op[31];
    assign dvd_neg = SIGNED & dvd_op[31];

    // A zero divisor always "fits", giving all-ones quotient and rem = dividend.
    assign shifted = {rem, quo[31]};
    assign diff    = shifted - {1'b0, dvs_mag};
    assign fits    = shifted[32] | ~diff[32];
    assign nxt_rem = fits ? diff[31:0] : shifted[31:0];
    assign nxt_quo = {quo[30:0], fits};

    always_ff @(posedge clk) begin
        if (reset) begin
            state                  <= IDLE;
            dvs_held               <= 1'b0;
            dvd_held               <= 1'b0;
            dvs_hold               <= '0;
            dvd_hold               <= '0;
            dvs_mag                <= '0;
            quo                    <= '0;
            rem                    <= '0;
            q_neg                  <= 1'b0;
            r_neg                  <= 1'b0;
            count                  <= '0;
            s_axis_divisor_tready  <= 1'b0;
            s_axis_dividend_tready <= 1'b0;
            m_axis_dout_tvalid     <= 1'b0;
            m_axis_dout_tdata      <= '0;
        end else begin
            m_axis_dout_tvalid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (dvs_xfer) begin
                        dvs_held <= 1'b1;
                        dvs_hold <= s_axis_divisor_tdata;
                    end
                    if (dvd_xfer) begin
                        dvd_held <= 1'b1;
                        dvd_hold <= s_axis_dividend_tdata;
                    end
                    if (start) begin
                        state   <= BUSY;
                        dvs_mag <= dvs_neg ? -dvs_op : dvs_op;
                        quo     <= dvd_neg ? -dvd_op : dvd_op;
                        rem     <= '0;
                        q_neg   <= dvd_neg ^ dvs_neg;
                        r_neg   <= dvd_neg;
                        count   <= '0;
                        s_axis_divisor_tready  <= 1'b0;
                        s_axis_dividend_tready <= 1'b0;
                    end else begin
                        s_axis_divisor_tready  <= ~(dvs_held | dvs_xfer);
                        s_axis_dividend_tready <= ~(dvd_held | dvd_xfer);
                    end
                end
                BUSY: begin
                    rem   <= nxt_rem;
                    quo   <= nxt_quo;
                    count <= count + 6'd1;
                    if (count == 6'd31) begin
                        state              <= DONE;
                        m_axis_dout_tvalid <= 1'b1;
                        m_axis_dout_tdata  <= {
                            r_neg ? -nxt_rem : nxt_rem,
                            q_neg ? -nxt_quo : nxt_quo
                        };
                    end
                end
                DONE: begin
                    state                  <= IDLE;
                    dvs_held               <= 1'b0;
                    dvd_held               <= 1'b0;
                    count                  <= '0;
                    s_axis_divisor_tready  <= 1'b1;
                    s_axis_dividend_tready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter_axis.sv
// Bench for div_iter_axis: signed and unsigned instances share stimulus
// and are checked against a plain-arithmetic division model.
module tb_div_iter_axis;

    logic        clk = 1'b0;
    logic        reset;
    logic        dvs_valid;
    logic [31:0] dvs_data;
    logic        dvd_valid;
    logic [31:0] dvd_data;

    logic        dvs_ready_s, dvd_ready_s, dout_valid_s;
    logic        dvs_ready_u, dvd_ready_u, dout_valid_u;
    logic [63:0] dout_data_s, dout_data_u;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    div_iter_axis #(.SIGNED(1'b1)) dut_s (
        .clk                    (clk),
        .reset                  (reset),
        .s_axis_divisor_tvalid  (dvs_valid),
        .s_axis_divisor_tready  (dvs_ready_s),
        .s_axis_divisor_tdata   (dvs_data),
        .s_axis_dividend_tvalid (dvd_valid),
        .s_axis_dividend_tready (dvd_ready_s),
        .s_axis_dividend_tdata  (dvd_data),
        .m_axis_dout_tvalid     (dout_valid_s),
        .m_axis_dout_tdata      (dout_data_s)
    );

    div_iter_axis #(.SIGNED(1'b0)) dut_u (
        .clk                    (clk),
        .reset                  (reset),
        .s_axis_divisor_tvalid  (dvs_valid),
        .s_axis_divisor_tready  (dvs_ready_u),
        .s_axis_divisor_tdata   (dvs_data),
        .s_axis_dividend_tvalid (dvd_valid),
        .s_axis_dividend_tready (dvd_ready_u),
        .s_axis_dividend_tdata  (dvd_data),
        .m_axis_dout_tvalid     (dout_valid_u),
        .m_axis_dout_tdata      (dout_data_u)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {remainder, quotient} from ordinary integer division rules.
    function automatic logic [63:0] model(input bit sgn,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            r = a;
            q = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
        end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a;
                r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return $urandom_range(0, 300);
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [3:0] readies();
        return {dvs_ready_s, dvd_ready_s, dvs_ready_u, dvd_ready_u};
    endfunction

    logic [63:0] last_s, last_u;

    task automatic wait_result(input logic [31:0] a, input logic [31:0] b);
        int k;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (dout_valid_u || dout_valid_s) break;
        end
        check("latency", 64'(k), 64'd33);
        check("both_valid", {dout_valid_s, dout_valid_u}, 2'b11);
        check("rdy_done", readies(), 4'h0);
        check("dout_u", dout_data_u, model(1'b0, a, b));
        check("dout_s", dout_data_s, model(1'b1, a, b));
        last_u = dout_data_u;
        last_s = dout_data_s;
    endtask

    // gap > 0: divisor first; gap < 0: dividend first; 0: same cycle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int gap);
        int n;
        check("rdy_idle", readies(), 4'hF);
        n = (gap < 0) ? -gap : gap;
        if (gap == 0) begin
            dvd_data  = a;
            dvs_data  = b;
            dvd_valid = 1'b1;
            dvs_valid = 1'b1;
            @(posedge clk); #1;
            dvd_valid = 1'b0;
            dvs_valid = 1'b0;
        end else begin
            if (gap > 0) begin
                dvs_data  = b;
                dvs_valid = 1'b1;
            end else begin
                dvd_data  = a;
                dvd_valid = 1'b1;
            end
            @(posedge clk); #1;
            dvs_valid = 1'b0;
            dvd_valid = 1'b0;
            for (int i = 1; i < n; i++) begin
                if (gap > 0) dvs_data = $urandom;
                else dvd_data = $urandom;
                @(negedge clk);
                check("gap_rdy", readies(), (gap > 0) ? 4'b0101 : 4'b1010);
                @(posedge clk); #1;
            end
            if (gap > 0) begin
                dvs_data  = $urandom;
                dvd_data  = a;
                dvd_valid = 1'b1;
            end else begin
                dvd_data  = $urandom;
                dvs_data  = b;
                dvs_valid = 1'b1;
            end
            @(posedge clk); #1;
            dvs_valid = 1'b0;
            dvd_valid = 1'b0;
        end
        dvs_data = $urandom;
        dvd_data = $urandom;
        wait_result(a, b);
        @(negedge clk);
        check("pulse_end", {dout_valid_s, dout_valid_u}, 2'b00);
        check("rdy_back", readies(), 4'hF);
        check("hold_u", dout_data_u, last_u);
        check("hold_s", dout_data_s, last_s);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int k;
        logic [31:0] ba [4];
        logic [31:0] bb [4];

        reset     = 1'b1;
        dvs_valid = 1'b0;
        dvd_valid = 1'b0;
        dvs_data  = '0;
        dvd_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdy", readies(), 4'h0);
        check("rst_valid", {dout_valid_s, dout_valid_u}, 2'b00);
        check("rst_data_u", dout_data_u, 64'd0);
        check("rst_data_s", dout_data_s, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_rdy", readies(), 4'hF);

        run_op(32'd100, 32'd7, 0);
        check("v100_7_u", last_u, 64'h00000002_0000000E);
        run_op(32'hFFFF_FFF9, 32'd2, 0);
        check("vm7_2_s", last_s, 64'hFFFFFFFF_FFFFFFFD);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 2);
        check("vmin_m1_s", last_s, 64'h00000000_80000000);
        run_op(32'd5, 32'd0, -1);
        check("v5_0_u", last_u, 64'h00000005_FFFFFFFF);
        run_op(32'hFFFF_FFFB, 32'd0, 0);
        check("vm5_0_s", last_s, 64'hFFFFFFFB_00000001);
        run_op(32'd9, 32'd3, 4);
        check("v9_3_u", last_u, 64'h00000000_00000003);
        check("v9_3_s", last_s, 64'h00000000_00000003);

        for (int i = 0; i < 24; i++)
            run_op(pick(), pick(), int'($urandom_range(0, 6)) - 3);

        // Abort mid-computation.
        dvd_data  = 32'd100;
        dvs_data  = 32'd7;
        dvd_valid = 1'b1;
        dvs_valid = 1'b1;
        @(posedge clk); #1;
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_rdy0", readies(), 4'h0);
        check("abort_data", dout_data_u, 64'd0);
        @(negedge clk);
        check("abort_rdy1", readies(), 4'hF);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (dout_valid_u || dout_valid_s) pulses++;
        end
        check("abort_nopulse", 64'(pulses), 64'd0);
        run_op(32'd20, 32'd6, 0);
        check("v20_6_u", last_u, 64'h00000002_00000003);

        // Back-to-back with both tvalid held high throughout.
        for (int i = 0; i < 4; i++) begin
            ba[i] = pick();
            bb[i] = pick();
        end
        dvd_data  = ba[0];
        dvs_data  = bb[0];
        dvd_valid = 1'b1;
        dvs_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (k = 0; k < 40; k++) begin
                @(negedge clk);
                if (readies() == 4'hF) break;
            end
            if (i > 0) check("b2b_rdy", 64'(k), 64'd0);
            @(posedge clk); #1;
            if (i < 3) begin
                dvd_data = ba[i+1];
                dvs_data = bb[i+1];
            end else begin
                dvd_valid = 1'b0;
                dvs_valid = 1'b0;
            end
            wait_result(ba[i], bb[i]);
        end
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (dout_valid_u || dout_valid_s) pulses++;
        end
        check("b2b_nodup", 64'(pulses), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
